// File: rtl/pipe_pkg.sv
// Shared types for the control-word pipeline registers: slot-count states and
// per-stage control structs that instantiations pack into the WIDTH-bit word.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } mw_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
    } em_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic [1:0] result_src;
        logic [2:0] alu_ctrl;
        logic       alu_src;
    } de_ctrl_t;

    function automatic logic [OCC_W-1:0] occ_of_state(input pipe_state_e s);
        logic [OCC_W-1:0] w_occ;
        w_occ = '0;
        case (s)
            ST_ONE:  w_occ = OCC_W'(1);
            ST_TWO:  w_occ = OCC_W'(2);
            default: w_occ = '0;
        endcase
        return w_occ;
    endfunction

endpackage

// File: rtl/ctrl_skid_slot.sv
// One held control word plus its valid bit. Clear wins over load so a flush
// can never be undone by a same-cycle refill.
module ctrl_skid_slot #(
    parameter int unsigned       WIDTH  = 3,
    parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_data  <= BUBBLE;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Control-word pipeline register with valid/ready handshake, synchronous flush
// and an optional second (skid) entry that keeps in_ready off the out_ready path.
module ctrl_pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = 3,
    parameter int unsigned      SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    pipe_state_e      r_state;
    pipe_state_e      w_state_d;
    logic             w_accept;
    logic             w_consume;
    logic             w_main_load;
    logic             w_main_clear;
    logic             w_skid_load;
    logic             w_skid_clear;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;
    logic [WIDTH-1:0] w_skid_q;
    logic             w_main_valid;
    logic             w_skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_d;
        end
    end

    // With a skid entry in_ready comes straight from the state register.
    assign in_ready  = (SKID != 0) ? (r_state != ST_TWO) : (!out_valid || out_ready);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = out_valid ? w_main_q : BUBBLE;
    assign occupancy = occ_of_state(r_state);
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;

    always_comb begin
        w_state_d    = r_state;
        w_main_load  = 1'b0;
        w_main_clear = 1'b0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        w_main_d     = in_data;
        if (flush) begin
            w_state_d    = ST_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_d   = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_load = 1'b1;
                    end else if (w_accept && (SKID != 0)) begin
                        w_state_d   = ST_TWO;
                        w_skid_load = 1'b1;
                    end else if (w_consume) begin
                        w_state_d    = ST_EMPTY;
                        w_main_clear = 1'b1;
                    end
                end
                ST_TWO: begin
                    // Skid entry moves up so it is never overtaken.
                    if (w_consume) begin
                        w_state_d    = ST_ONE;
                        w_main_load  = 1'b1;
                        w_main_d     = w_skid_q;
                        w_skid_clear = 1'b1;
                    end
                end
                default: begin
                    w_state_d    = ST_EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    ctrl_skid_slot #(
        .WIDTH  (WIDTH),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_d),
        .o_valid (w_main_valid),
        .o_data  (w_main_q)
    );

    if (SKID != 0) begin : g_skid
        ctrl_skid_slot #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_data  (in_data),
            .o_valid (w_skid_valid),
            .o_data  (w_skid_q)
        );
    end else begin : g_no_skid
        assign w_skid_valid = 1'b0;
        assign w_skid_q     = BUBBLE;
    end

    a_no_accept_in_two: assert property (@(posedge clk) disable iff (!rst_n)
        !((r_state == ST_TWO) && w_accept));

    a_occ_matches_valids: assert property (@(posedge clk) disable iff (!rst_n)
        occupancy == OCC_W'($countones({w_skid_valid, w_main_valid})));

    a_bubble_when_invalid: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid || (out_data == BUBBLE));

endmodule
